// File: rtl/qam_pkg.sv
// Types and constants shared between the serial packer and the 16-QAM mapper.
package qam_pkg;

  localparam int unsigned BITS_PER_SYM = 4;

  typedef logic [BITS_PER_SYM-1:0] sym_t;

  localparam sym_t DEFAULT_IDLE_SYM = 4'b0000;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial bit handshake in, symbol-rate nibble stream plus underflow status out.
interface serial_to_parallel_if;
  import qam_pkg::*;

  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  sym_t        parallel_out;
  logic        sym_strobe;
  logic        underflow;
  logic [15:0] underflow_cnt;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, parallel_out, sym_strobe, underflow, underflow_cnt
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, parallel_out, sym_strobe, underflow, underflow_cnt
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; a pop advances the read pointer on the edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  always_comb begin
    full_o  = (count_q == CW'(DEPTH));
    empty_o = (count_q == '0);
    // A pop on an empty FIFO is ignored even if a push lands on the same edge.
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Packs a serial bit stream MSB-first into nibbles and releases one per symbol period.
module serial_to_parallel
  import qam_pkg::*;
#(
  parameter int unsigned SYM_PERIOD = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter sym_t        IDLE_SYM   = DEFAULT_IDLE_SYM
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_to_parallel_if.slave  bus
);

  localparam int unsigned SCW = $clog2(SYM_PERIOD);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_PERIOD - 1);

  logic [SCW-1:0] sym_cnt_q;
  logic [1:0]     bit_cnt_q;
  logic [2:0]     partial_q;
  sym_t           parallel_out_q;
  logic           sym_strobe_q;
  logic           underflow_q;
  logic [15:0]    underflow_cnt_q;

  logic           fifo_full, fifo_empty;
  sym_t           fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           bit_ready, accept, push, tick, pop;

  always_comb begin
    // No pop lookahead: a full FIFO only stalls the bit that would complete a nibble.
    bit_ready = !(fifo_full && bit_cnt_q == 2'd3);
    accept    = bus.bit_valid && bit_ready;
    push      = accept && bit_cnt_q == 2'd3;
    tick      = (sym_cnt_q == SYM_LAST);
    pop       = tick && !fifo_empty;
  end

  sync_fifo #(
    .WIDTH (BITS_PER_SYM),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({partial_q, bus.bit_in}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      partial_q       <= '0;
      parallel_out_q  <= IDLE_SYM;
      sym_strobe_q    <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      sym_cnt_q    <= tick ? '0 : sym_cnt_q + SCW'(1);
      sym_strobe_q <= tick;
      underflow_q  <= tick && fifo_empty;
      if (tick) begin
        if (!fifo_empty) begin
          parallel_out_q <= fifo_head;
        end else begin
          parallel_out_q <= IDLE_SYM;
          if (underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 16'd1;
        end
      end
      if (accept) begin
        bit_cnt_q <= bit_cnt_q + 2'd1;
        partial_q <= {partial_q[1:0], bus.bit_in};
      end
    end
  end

  always_comb begin
    bus.bit_ready     = bit_ready;
    bus.parallel_out  = parallel_out_q;
    bus.sym_strobe    = sym_strobe_q;
    bus.underflow     = underflow_q;
    bus.underflow_cnt = underflow_cnt_q;
  end

  fifo_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: behavioural model feeds a scoreboard of strobes.
module tb_serial_to_parallel;
  import qam_pkg::*;

  localparam int P = 16;
  localparam int D = 4;

  typedef struct packed {
    logic uf;
    sym_t sym;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_to_parallel_if bus();

  serial_to_parallel #(
    .SYM_PERIOD (P),
    .FIFO_DEPTH (D),
    .IDLE_SYM   (4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  // Reference model: expected strobe contents are pushed on each modelled tick.
  exp_t       sb[$];
  sym_t       m_fifo[$];
  int         m_sym, m_bcnt, m_ucnt;
  logic [2:0] m_part;
  logic       m_acc, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sym = 0; m_bcnt = 0; m_ucnt = 0; m_part = '0;
      m_fifo.delete();
      sb.delete();
    end else begin
      m_acc  = bus.bit_valid && !(m_fifo.size() == D && m_bcnt == 3);
      m_tick = (m_sym == P - 1);
      m_sym  = (m_sym + 1) % P;
      if (m_tick) begin
        if (m_fifo.size() > 0) begin
          sb.push_back({1'b0, m_fifo.pop_front()});
        end else begin
          sb.push_back({1'b1, 4'b0000});
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
      if (m_acc) begin
        if (m_bcnt == 3) m_fifo.push_back({m_part, bus.bit_in});
        m_part = {m_part[1:0], bus.bit_in};
        m_bcnt = (m_bcnt + 1) % 4;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    #1;
    total += 5;
    if (bus.parallel_out !== 4'b0000) begin bad++; $display("FAIL reset_out got %b want 0000", bus.parallel_out); end
    if (bus.sym_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got %b want 0", bus.sym_strobe); end
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_uf got %b want 0", bus.underflow); end
    if (bus.underflow_cnt !== 16'd0) begin bad++; $display("FAIL reset_ucnt got %0d want 0", bus.underflow_cnt); end
    if (bus.bit_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.bit_ready); end
  endtask

  task automatic test_idle_underflow();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      total++;
      if (bus.sym_strobe !== (k % P == 0)) begin
        bad++; $display("FAIL idle_strobe edge %0d got %b want %b", k, bus.sym_strobe, k % P == 0);
      end
      if (bus.sym_strobe) begin
        e = sb.pop_front();
        total++;
        if (bus.parallel_out !== e.sym || bus.underflow !== e.uf) begin
          bad++; $display("FAIL idle_sym edge %0d got %b/%b want %b/%b", k, bus.parallel_out,
                          bus.underflow, e.sym, e.uf);
        end
      end
    end
    total++;
    if (bus.underflow_cnt !== 16'd3) begin bad++; $display("FAIL idle_ucnt got %0d want 3", bus.underflow_cnt); end
  endtask

  // Drives pat MSB-first on edges first..first+3 and checks strobes up to edge last.
  task automatic test_nibble(input string name, input logic [3:0] pat, input int first,
                             input int last, input int data_edge);
    do_reset();
    for (int k = 1; k <= last; k++) begin
      bus.bit_valid = (k >= first && k <= first + 3);
      bus.bit_in = 1'b0;
      if (k >= first && k <= first + 3) bus.bit_in = pat[first + 3 - k];
      @(negedge clk);
      total++;
      if (bus.sym_strobe !== (k % P == 0)) begin
        bad++; $display("FAIL %s_strobe edge %0d got %b", name, k, bus.sym_strobe);
      end
      if (bus.sym_strobe && k == data_edge) begin
        total++;
        if (bus.parallel_out !== pat || bus.underflow !== 1'b0) begin
          bad++; $display("FAIL %s_data edge %0d got %b/%b want %b/0", name, k, bus.parallel_out,
                          bus.underflow, pat);
        end
      end else if (bus.sym_strobe) begin
        total++;
        if (bus.parallel_out !== 4'b0000 || bus.underflow !== 1'b1) begin
          bad++; $display("FAIL %s_idle edge %0d got %b/%b want 0000/1", name, k, bus.parallel_out,
                          bus.underflow);
        end
      end
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic src[$];
    sym_t nib_q[$];
    exp_t e;
    logic rdy_prev, saw_low;
    int idx, got, cyc;
    do_reset();
    for (int i = 0; i < 8 * D; i++) src.push_back(1'($urandom_range(1)));
    for (int g = 0; g < 2 * D; g++) nib_q.push_back({src[4*g], src[4*g+1], src[4*g+2], src[4*g+3]});
    idx = 0; got = 0; cyc = 0; saw_low = 1'b0;
    rdy_prev = bus.bit_ready;
    bus.bit_valid = 1'b1;
    bus.bit_in = src[0];
    while (got < 2 * D && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.bit_valid && rdy_prev) idx++;
      if (bus.sym_strobe) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_sb strobe at cycle %0d with nothing expected", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.underflow !== e.uf) begin
            bad++; $display("FAIL b2b_uf cycle %0d got %b want %b", cyc, bus.underflow, e.uf);
          end else if (!e.uf) begin
            if (bus.parallel_out !== nib_q[0]) begin
              bad++; $display("FAIL b2b_order nibble %0d got %b want %b", got, bus.parallel_out,
                              nib_q[0]);
            end
            void'(nib_q.pop_front());
            got++;
          end
        end
      end
      total++;
      if (bus.bit_ready !== !(m_fifo.size() == D && m_bcnt == 3)) begin
        bad++; $display("FAIL b2b_ready cycle %0d got %b want %b", cyc, bus.bit_ready,
                        !(m_fifo.size() == D && m_bcnt == 3));
      end
      if (!bus.bit_ready) saw_low = 1'b1;
      rdy_prev = bus.bit_ready;
      bus.bit_valid = (idx < 8 * D);
      bus.bit_in = (idx < 8 * D) ? src[idx] : 1'b0;
    end
    bus.bit_valid = 1'b0;
    total += 2;
    if (got != 2 * D) begin bad++; $display("FAIL b2b_count got %0d want %0d", got, 2 * D); end
    if (saw_low !== 1'b1) begin bad++; $display("FAIL b2b_backpressure got %b want 1", saw_low); end
  endtask

  task automatic test_async_reset();
    logic [13:0] src;
    do_reset();
    src = 14'($urandom());
    for (int k = 1; k <= 32; k++) begin
      bus.bit_valid = (k >= 17 && k <= 30);
      bus.bit_in = 1'b0;
      if (k >= 17 && k <= 30) bus.bit_in = src[30 - k];
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    total += 3;
    if (bus.sym_strobe !== 1'b1) begin bad++; $display("FAIL arst_pre_strobe got %b want 1", bus.sym_strobe); end
    if (bus.parallel_out !== src[13:10]) begin
      bad++; $display("FAIL arst_pre_out got %b want %b", bus.parallel_out, src[13:10]);
    end
    if (bus.underflow_cnt !== 16'd1) begin bad++; $display("FAIL arst_pre_ucnt got %0d want 1", bus.underflow_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (bus.parallel_out !== 4'b0000) begin bad++; $display("FAIL arst_out got %b want 0000", bus.parallel_out); end
    if (bus.sym_strobe !== 1'b0) begin bad++; $display("FAIL arst_strobe got %b want 0", bus.sym_strobe); end
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL arst_uf got %b want 0", bus.underflow); end
    if (bus.underflow_cnt !== 16'd0) begin bad++; $display("FAIL arst_ucnt got %0d want 0", bus.underflow_cnt); end
    if (bus.bit_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got %b want 1", bus.bit_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      total++;
      if (bus.sym_strobe !== (k == P)) begin bad++; $display("FAIL arst_phase edge %0d got %b", k, bus.sym_strobe); end
    end
    total++;
    if (bus.parallel_out !== 4'b0000 || bus.underflow !== 1'b1) begin
      bad++; $display("FAIL arst_first got %b/%b want 0000/1", bus.parallel_out, bus.underflow);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.underflow_cnt_q = 16'hFFFD;
    m_ucnt = 65533;
    @(negedge clk);
    release dut.underflow_cnt_q;
    for (int k = 2; k <= 48; k++) begin
      @(negedge clk);
      if (bus.sym_strobe) begin
        total++;
        if (bus.underflow_cnt !== 16'(m_ucnt)) begin
          bad++; $display("FAIL sat_step edge %0d got %h want %h", k, bus.underflow_cnt, 16'(m_ucnt));
        end
      end
    end
    total++;
    if (bus.underflow_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_final got %h want ffff", bus.underflow_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_underflow();
    test_nibble("single", 4'b1011, 1, 16, 16);
    test_nibble("tickpush", 4'b0110, 13, 32, 32);
    test_back_to_back();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
